// File: rtl/mux_nto1_rr.sv
// N-channel registered multiplexer with valid/ready handshakes, fixed-select or
// round-robin arbitration, and a source-channel tag on every output word.
module mux_nto1_rr #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned SWIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SWIDTH-1:0]    sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SWIDTH-1:0]    out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SWIDTH-1:0] out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SWIDTH-1:0] last_q, last_d;

  logic              load_c;
  logic              found_c;
  logic              xfer_c;
  logic [N-1:0]      grant_c;
  logic [SWIDTH-1:0] gnt_idx_c;
  logic [WIDTH-1:0]  gnt_data_c;
  logic [SWIDTH-1:0] tgt_c;

  // Output register can take a word when empty or being drained this cycle.
  assign load_c = !out_valid_q | out_ready;

  // Grant: fixed select, or first valid channel after the last winner.
  always_comb begin
    grant_c    = '0;
    gnt_idx_c  = '0;
    gnt_data_c = '0;
    tgt_c      = '0;
    found_c    = 1'b0;
    if (!mode) begin
      // A select value at or above N matches no channel, so nothing is granted.
      for (int unsigned k = 0; k < N; k++) begin
        if (sel == SWIDTH'(k) && in_valid[k]) begin
          grant_c[k] = 1'b1;
          gnt_idx_c  = SWIDTH'(k);
          gnt_data_c = in_data[k*WIDTH +: WIDTH];
          found_c    = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= N; i++) begin
        tgt_c = SWIDTH'((32'(last_q) + i) % N);
        for (int unsigned k = 0; k < N; k++) begin
          if (!found_c && in_valid[k] && tgt_c == SWIDTH'(k)) begin
            grant_c[k] = 1'b1;
            gnt_idx_c  = SWIDTH'(k);
            gnt_data_c = in_data[k*WIDTH +: WIDTH];
            found_c    = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready = grant_c & {N{load_c}};
  assign xfer_c   = found_c & load_c;

  // Next state: reload on a transfer, otherwise empty the register once accepted.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer_c) begin
      out_data_d  = gnt_data_c;
      out_ch_d    = gnt_idx_c;
      out_valid_d = 1'b1;
      if (mode) begin
        last_d = gnt_idx_c;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to N-1 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SWIDTH'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a table of per-cycle vectors on a 4-channel
// instance plus hand sequences for async reset and a 3-channel invalid select.
module tb_mux_nto1_rr;

  logic        clk;
  logic        rst_n;

  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int errors = 0;
  int checks = 0;

  mux_nto1_rr #(.WIDTH(4), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_rr #(.WIDTH(4), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [3:0]  e_od;
    logic [1:0]  e_oc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic m, logic [1:0] s, logic [3:0] v,
                              logic [15:0] d, logic r, logic [3:0] er, logic eov,
                              logic [3:0] eod, logic [1:0] eoc);
    vec_t t;
    t.name = name; t.mode = m; t.sel = s; t.vld = v; t.data = d; t.ordy = r;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_oc = eoc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    mode = v.mode; sel = v.sel; in_valid = v.vld; in_data = v.data; out_ready = v.ordy;
    #1;
    check({v.name, ".in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    check({v.name, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({v.name, ".out_data"}, 32'(out_data), 32'(v.e_od));
    check({v.name, ".out_ch"}, 32'(out_ch), 32'(v.e_oc));
  endtask

  initial begin
    // Fixed select of channel 2.
    vecs.push_back(mk("fix0",  1'b0, 2'd2, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2));
    vecs.push_back(mk("fix1",  1'b0, 2'd2, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2));
    vecs.push_back(mk("fixnv", 1'b0, 2'd1, 4'b1101, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2));
    // Round-robin, all valid: pointer still at 3 from reset.
    vecs.push_back(mk("rr0",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0));
    vecs.push_back(mk("rr1",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1));
    vecs.push_back(mk("rr2",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd2));
    vecs.push_back(mk("rr3",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    vecs.push_back(mk("rr4",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0));
    vecs.push_back(mk("rr5",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1));
    // Sparse valid 1010 starting after pointer 1.
    vecs.push_back(mk("sp0",   1'b1, 2'd0, 4'b1010, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    vecs.push_back(mk("sp1",   1'b1, 2'd0, 4'b1010, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1));
    vecs.push_back(mk("sp2",   1'b1, 2'd0, 4'b1010, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    vecs.push_back(mk("sp3",   1'b1, 2'd0, 4'b1010, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1));
    // Backpressure: word from ch2, held for 3 cycles while inputs change.
    vecs.push_back(mk("bp0",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd2));
    vecs.push_back(mk("bp1",   1'b1, 2'd0, 4'b1111, 16'hFFFF, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd2));
    vecs.push_back(mk("bp2",   1'b1, 2'd0, 4'b1111, 16'h7654, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd2));
    vecs.push_back(mk("bp3",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd2));
    vecs.push_back(mk("bp4",   1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    // Mode switch: 1 (rr), 3, 3 (fixed), then rr resumes after 1 -> 2.
    vecs.push_back(mk("ms0",   1'b1, 2'd0, 4'b0010, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1));
    vecs.push_back(mk("ms1",   1'b0, 2'd3, 4'b1111, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    vecs.push_back(mk("ms2",   1'b0, 2'd3, 4'b1111, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3));
    vecs.push_back(mk("ms3",   1'b1, 2'd3, 4'b1111, 16'h3210, 1'b1, 4'b0100, 1'b1, 4'h2, 2'd2));
    // Drain: accepted word leaves, data and channel hold.
    vecs.push_back(mk("dr0",   1'b1, 2'd0, 4'b0000, 16'h3210, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd2));
    vecs.push_back(mk("dr1",   1'b1, 2'd0, 4'b0000, 16'h3210, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd2));

    rst_n = 1'b0;
    mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_ch", 32'(out_ch), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset while a word is held drops it without a clock edge.
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b0010; in_data = 16'h3210; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("ar.loaded", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.out_data", 32'(out_data), 32'd0);
    check("ar.out_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check("ar.ptr_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("ar.ptr_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    in_valid = 4'b0000;

    // Three-channel instance: sel = 3 is out of range and grants nothing.
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; in_data3 = 12'h987; out_ready3 = 1'b1;
    #1;
    check("n3.rdy_sel0", 32'(in_ready3), 32'b001);
    @(posedge clk);
    #1;
    check("n3.ov_sel0", 32'(out_valid3), 32'd1);
    check("n3.od_sel0", 32'(out_data3), 32'h7);
    @(negedge clk);
    sel3 = 2'd2;
    #1;
    check("n3.rdy_sel2", 32'(in_ready3), 32'b100);
    @(posedge clk);
    #1;
    check("n3.od_sel2", 32'(out_data3), 32'h9);
    check("n3.oc_sel2", 32'(out_ch3), 32'd2);
    @(negedge clk);
    sel3 = 2'd3;
    #1;
    check("n3.rdy_sel3", 32'(in_ready3), 32'b000);
    @(posedge clk);
    #1;
    check("n3.ov_sel3", 32'(out_valid3), 32'd0);
    check("n3.od_hold", 32'(out_data3), 32'h9);
    @(posedge clk);
    #1;
    check("n3.ov_idle", 32'(out_valid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
